// File: rtl/layer_serializer.sv
// layer_serializer: collects one layer's per-neuron results (arriving on any
// cycle, in any order) into a hold buffer, then streams the completed frame out
// one word per cycle while the next frame is being collected.
module layer_serializer #(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             i_valid,
    input  logic [NN*dataWidth-1:0]   i_data,
    output logic                      o_valid,
    output logic [dataWidth-1:0]      o_data,
    output logic                      o_last,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_d;
    logic [NN-1:0]        mask;
    logic [dataWidth-1:0] hold  [NN];
    logic [dataWidth-1:0] shreg [NN];
    logic                 full_c;
    logic                 load_c;
    logic [dataWidth-1:0] data_d;

    // Next-state, load decision and next output word
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        full_c  = &mask;
        load_c  = 1'b0;
        data_d  = '0;

        case (state)
            IDLE: begin
                load_c = full_c;
                if (load_c) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt != LAST_IDX) begin
                    cnt_d = cnt + CW'(1);
                end else begin
                    load_c  = full_c;
                    cnt_d   = '0;
                    state_d = load_c ? SHIFT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // On a load the shift register is being refilled from hold this edge
        if (load_c) begin
            data_d = hold[0];
        end else if (state_d == SHIFT) begin
            data_d = shreg[cnt_d];
        end
    end

    // State and word-counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Hold buffer, arrival mask and sticky overrun flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NN; k++) begin
                hold[k] <= '0;
            end
            mask    <= '0;
            overrun <= 1'b0;
        end else begin
            for (int k = 0; k < NN; k++) begin
                if (i_valid[k]) begin
                    hold[k] <= i_data[k*dataWidth +: dataWidth];
                end
            end
            // Arrivals on a load edge start the next frame's mask
            if (load_c) begin
                mask <= i_valid;
            end else begin
                mask <= mask | i_valid;
                if (|(i_valid & mask)) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // Shift register capture and registered serial outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NN; k++) begin
                shreg[k] <= '0;
            end
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (load_c) begin
                for (int k = 0; k < NN; k++) begin
                    shreg[k] <= hold[k];
                end
            end
            o_valid <= (state_d == SHIFT);
            busy    <= (state_d == SHIFT);
            o_last  <= (state_d == SHIFT) && (cnt_d == LAST_IDX);
            o_data  <= data_d;
        end
    end

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: a 30-word and a 4-word instance share clock and
// reset; expected words are queued as frames are driven and checked on output.
module tb_layer_serializer;

    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [29:0]      iv30;
    logic [30*DW-1:0] id30;
    logic             ov30, ol30, busy30, ovr30;
    logic [DW-1:0]    od30;

    logic [3:0]       iv4;
    logic [4*DW-1:0]  id4;
    logic             ov4, ol4, busy4, ovr4;
    logic [DW-1:0]    od4;

    layer_serializer #(.NN(30), .dataWidth(DW)) u_dut30 (
        .clk(clk), .rst(rst), .i_valid(iv30), .i_data(id30),
        .o_valid(ov30), .o_data(od30), .o_last(ol30), .busy(busy30), .overrun(ovr30)
    );

    layer_serializer #(.NN(4), .dataWidth(DW)) u_dut4 (
        .clk(clk), .rst(rst), .i_valid(iv4), .i_data(id4),
        .o_valid(ov4), .o_data(od4), .o_last(ol4), .busy(busy4), .overrun(ovr4)
    );

    int total = 0;
    int bad   = 0;

    logic [16:0] q30[$];
    logic [16:0] q4[$];
    int run30 = 0, run4 = 0, last_run30 = 0, last_run4 = 0;

    // Single comparison point: count, and report a mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor for the 30-word instance
    always @(negedge clk) begin : mon30
        logic [16:0] e;
        if (rst) begin
            check("busy30", 32'(busy30), 32'(ov30));
            if (ov30) begin
                run30++;
                if (q30.size() == 0) check("unexp30", 32'(1), 32'(0));
                else begin
                    e = q30.pop_front();
                    check("data30", 32'(od30), 32'(e[15:0]));
                    check("last30", 32'(ol30), 32'(e[16]));
                end
            end else begin
                check("nolast30", 32'(ol30), 32'(0));
                if (run30 != 0) begin
                    last_run30 = run30;
                    run30 = 0;
                end
            end
        end else begin
            run30 = 0;
        end
    end

    // Output monitor for the 4-word instance
    always @(negedge clk) begin : mon4
        logic [16:0] e;
        if (rst) begin
            check("busy4", 32'(busy4), 32'(ov4));
            if (ov4) begin
                run4++;
                if (q4.size() == 0) check("unexp4", 32'(1), 32'(0));
                else begin
                    e = q4.pop_front();
                    check("data4", 32'(od4), 32'(e[15:0]));
                    check("last4", 32'(ol4), 32'(e[16]));
                end
            end else begin
                check("nolast4", 32'(ol4), 32'(0));
                if (run4 != 0) begin
                    last_run4 = run4;
                    run4 = 0;
                end
            end
        end else begin
            run4 = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        iv4  = '0;
        iv30 = '0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) tick();
    endtask

    task automatic set4(input int k, input logic [15:0] w);
        iv4[k] = 1'b1;
        id4[k*DW +: DW] = w;
    endtask

    task automatic set_all4(input logic [15:0] w0, w1, w2, w3);
        set4(0, w0); set4(1, w1); set4(2, w2); set4(3, w3);
    endtask

    task automatic push4(input logic [15:0] w0, w1, w2, w3);
        q4.push_back({1'b0, w0});
        q4.push_back({1'b0, w1});
        q4.push_back({1'b0, w2});
        q4.push_back({1'b1, w3});
    endtask

    initial begin
        rst  = 1'b0;
        iv30 = '0; id30 = '0;
        iv4  = '0; id4  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ov30",   32'(ov30),   32'(0));
        check("rst_od30",   32'(od30),   32'(0));
        check("rst_ol30",   32'(ol30),   32'(0));
        check("rst_busy30", 32'(busy30), 32'(0));
        check("rst_ovr30",  32'(ovr30),  32'(0));
        check("rst_ov4",    32'(ov4),    32'(0));
        check("rst_od4",    32'(od4),    32'(0));
        check("rst_ol4",    32'(ol4),    32'(0));
        check("rst_busy4",  32'(busy4),  32'(0));
        check("rst_ovr4",   32'(ovr4),   32'(0));
        rst = 1'b1;
        tick();

        // Single 30-word frame, all bits in one cycle
        for (int k = 0; k < 30; k++) begin
            iv30[k] = 1'b1;
            id30[k*DW +: DW] = 16'(16'h0100 + k);
            q30.push_back({(k == 29), 16'(16'h0100 + k)});
        end
        tick();
        clr();
        @(negedge clk);
        check("lat_e0", 32'(ov30), 32'(0));
        tick();
        @(negedge clk);
        check("lat_e1", 32'(ov30), 32'(1));
        idle(32);
        check("run30", 32'(last_run30), 32'(30));
        check("ovr30", 32'(ovr30), 32'(0));

        // Staggered arrival 3,0,2,1
        set4(3, 16'h00A3); tick(); clr();
        @(negedge clk); check("stag_b3", 32'(ov4), 32'(0));
        set4(0, 16'h00A0); tick(); clr();
        @(negedge clk); check("stag_b0", 32'(ov4), 32'(0));
        set4(2, 16'h00A2); tick(); clr();
        @(negedge clk); check("stag_b2", 32'(ov4), 32'(0));
        push4(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
        set4(1, 16'h00A1); tick(); clr();
        @(negedge clk); check("stag_full", 32'(ov4), 32'(0));
        tick();
        @(negedge clk); check("stag_start", 32'(ov4), 32'(1));
        idle(8);
        check("stag_run", 32'(last_run4), 32'(4));

        // Back-to-back: frame B collected while A shifts
        push4(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3);
        push4(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3);
        set_all4(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3); tick(); clr();
        tick();
        set_all4(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3); tick(); clr();
        idle(12);
        check("b2b_run", 32'(last_run4), 32'(8));
        check("b2b_ovr", 32'(ovr4), 32'(0));

        // Arrival on the load edge belongs to the next frame
        push4(16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3);
        push4(16'h00E0, 16'h00E1, 16'h00E2, 16'h00E3);
        set_all4(16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3); tick(); clr();
        set4(2, 16'h00E2); tick(); clr();
        set4(0, 16'h00E0); set4(1, 16'h00E1); set4(3, 16'h00E3); tick(); clr();
        idle(12);
        check("ledge_ovr", 32'(ovr4), 32'(0));
        check("ledge_run", 32'(last_run4), 32'(8));

        // Overrun: bit 1 twice before the frame completes
        push4(16'h0050, 16'h0022, 16'h0052, 16'h0053);
        set4(1, 16'h0011); tick(); clr();
        @(negedge clk); check("ovr_pre", 32'(ovr4), 32'(0));
        set4(1, 16'h0022); tick(); clr();
        @(negedge clk); check("ovr_set", 32'(ovr4), 32'(1));
        set4(0, 16'h0050); set4(2, 16'h0052); set4(3, 16'h0053); tick(); clr();
        idle(8);
        check("ovr_sticky", 32'(ovr4), 32'(1));

        // Mid-frame reset after word 1
        push4(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3);
        set_all4(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3); tick(); clr();
        tick();
        tick();
        @(negedge clk);
        #1;
        rst = 1'b0;
        q4.delete();
        #1;
        check("mrst_ov",   32'(ov4),   32'(0));
        check("mrst_busy", 32'(busy4), 32'(0));
        check("mrst_last", 32'(ol4),   32'(0));
        check("mrst_ovr",  32'(ovr4),  32'(0));
        @(negedge clk);
        rst = 1'b1;
        idle(6);
        set4(0, 16'h0070); set4(1, 16'h0071); set4(2, 16'h0072); tick(); clr();
        idle(4);
        check("mrst_quiet", 32'(ov4), 32'(0));
        push4(16'h0070, 16'h0071, 16'h0072, 16'h0073);
        set4(3, 16'h0073); tick(); clr();
        idle(8);
        check("mrst_run", 32'(last_run4), 32'(4));

        check("drain4",  32'(q4.size()),  32'(0));
        check("drain30", 32'(q30.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
